rf_wr_arbiter: RTL and testbench

- Shares the single register-file write port (we/wa/wd) among NREQ writeback requesters, e.g. ALU writeback, load unit and debug/host write.
- Round-robin grant with a valid/ready handshake per requester.
- One registered output stage drives the register-file write port directly.
- Writes to x0 are accepted and discarded here; each discard is counted.

---
 rtl/rf_wr_arbiter_if.sv | 15 +
 rtl/rf_wr_arbiter.sv | 98 +++++++++
 tb/tb_rf_wr_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/rf_wr_arbiter_if.sv
// Requester-side write handshake bundle for rf_wr_arbiter.
// A transfer happens on a cycle where req_valid[i] & req_ready[i]; requesters hold valid/wa/wd until then.
interface rf_wr_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_wa;
    logic [NREQ*DW-1:0] req_wd;
    logic [NREQ-1:0]    req_ready;

    modport master (output req_valid, req_wa, req_wd, input req_ready);
    modport slave  (input req_valid, req_wa, req_wd, output req_ready);
endinterface

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ requesters.
// Optional read-bypass of the in-flight write is enabled by defining RF_WR_BYPASS_EN.
module rf_wr_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int CW   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    rf_wr_arbiter_if.slave       req,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_wa,
    output logic [DW-1:0]        rf_wd,
    output logic [2:0]           grant_id,
    output logic [CW-1:0]        x0_drop_cnt,
    input  logic [AW-1:0]        byp_ra,
    output logic                 byp_hit,
    output logic [DW-1:0]        byp_data
);

    logic [2:0]    ptr;
    logic [2:0]    gnt_idx;
    logic          gnt_vld;
    logic [7:0]    vld8;
    logic [AW-1:0] wa_arr [8];
    logic [DW-1:0] wd_arr [8];
    logic [AW-1:0] gnt_wa;
    logic [DW-1:0] gnt_wd;
    logic [3:0]    sum;

    // Pad the requester vectors to 8 entries so a 3-bit index selects exactly.
    always_comb begin
        vld8 = 8'(req.req_valid);
        for (int i = 0; i < 8; i++) begin
            wa_arr[i] = '0;
            wd_arr[i] = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            wa_arr[i] = req.req_wa[i*AW +: AW];
            wd_arr[i] = req.req_wd[i*DW +: DW];
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + 4'(k);
            if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
            if (!gnt_vld && vld8[sum[2:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = sum[2:0];
            end
        end
        if (rst || stall) gnt_vld = 1'b0;
    end

    assign req.req_ready = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;
    assign gnt_wa        = wa_arr[gnt_idx];
    assign gnt_wd        = wd_arr[gnt_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we       <= 1'b0;
            rf_wa       <= '0;
            rf_wd       <= '0;
            grant_id    <= '0;
            x0_drop_cnt <= '0;
            ptr         <= '0;
        end else begin
            rf_we <= 1'b0;
            if (gnt_vld) begin
                grant_id <= gnt_idx;
                ptr      <= (gnt_idx == 3'(NREQ-1)) ? 3'd0 : gnt_idx + 3'd1;
                if (gnt_wa != '0) begin
                    rf_we <= 1'b1;
                    rf_wa <= gnt_wa;
                    rf_wd <= gnt_wd;
                end else if (x0_drop_cnt != '1) begin
                    // x0 writes are swallowed here; only the count moves.
                    x0_drop_cnt <= x0_drop_cnt + 1'b1;
                end
            end
        end
    end

`ifdef RF_WR_BYPASS_EN
    assign byp_hit  = rf_we && (rf_wa == byp_ra) && (byp_ra != '0);
    assign byp_data = byp_hit ? rf_wd : '0;
`else
    assign byp_hit  = 1'b0;
    assign byp_data = '0;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: table of grant vectors plus hand sequences; output stage
// checked against an expected queue filled from the table's expected grants.
module tb_rf_wr_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int CW   = 8;

  logic          clk;
  logic          rst;
  logic          stall;
  logic [AW-1:0] byp_ra;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [2:0]    grant_id;
  logic [CW-1:0] x0_drop_cnt;
  logic          byp_hit;
  logic [DW-1:0] byp_data;

  rf_wr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  rf_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .req         (bus),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .grant_id    (grant_id),
    .x0_drop_cnt (x0_drop_cnt),
    .byp_ra      (byp_ra),
    .byp_hit     (byp_hit),
    .byp_data    (byp_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [2:0]    gid;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    logic       st;
    logic [2:0] valid;
    logic [4:0] wa0, wa1, wa2;
    logic [2:0] exp_ready;
  } vec_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   errors;
  int   checks;
  vec_t tbl[16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // driver: one cycle of stimulus; compares the current outputs and the grant,
  // then pushes the expected output state for the next cycle
  task automatic apply(input logic st, input logic [2:0] v, input logic [14:0] wa,
                       input logic [95:0] wd, input logic [2:0] er, input logic [4:0] bra);
    exp_t e;
    exp_t n;
    int   g;
    logic [4:0] gwa;
    logic       ehit;
    stall         = st;
    bus.req_valid = v;
    bus.req_wa    = wa;
    bus.req_wd    = wd;
    byp_ra        = bra;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rf_we", 64'(rf_we), 64'(e.we));
      chk("rf_wa", 64'(rf_wa), 64'(e.wa));
      chk("rf_wd", 64'(rf_wd), 64'(e.wd));
      chk("grant_id", 64'(grant_id), 64'(e.gid));
      chk("x0_drop_cnt", 64'(x0_drop_cnt), 64'(e.cnt));
`ifdef RF_WR_BYPASS_EN
      ehit = e.we && (e.wa == bra) && (bra != 5'd0);
      chk("byp_hit", 64'(byp_hit), 64'(ehit));
      chk("byp_data", 64'(byp_data), ehit ? 64'(e.wd) : 64'd0);
`else
      ehit = 1'b0;
      chk("byp_hit", 64'(byp_hit), 64'(ehit));
      chk("byp_data", 64'(byp_data), 64'd0);
`endif
    end
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    n    = last_exp;
    n.we = 1'b0;
    if (er != 3'b000) begin
      g     = er[1] ? 1 : (er[2] ? 2 : 0);
      gwa   = wa[g*5 +: 5];
      n.gid = 3'(g);
      if (gwa != 5'd0) begin
        n.we = 1'b1;
        n.wa = gwa;
        n.wd = wd[g*32 +: 32];
      end else if (n.cnt != 8'hff) begin
        n.cnt = n.cnt + 8'd1;
      end
    end
    exp_q.push_back(n);
    last_exp = n;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    stall         = 1'b0;
    bus.req_valid = 3'b111;
    bus.req_wa    = {5'd3, 5'd2, 5'd1};
    bus.req_wd    = '0;
    byp_ra        = 5'd0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_wa", 64'(rf_wa), 64'd0);
    chk("rst_wd", 64'(rf_wd), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_cnt", 64'(x0_drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    last_exp = '0;
    exp_q.push_back(last_exp);
  endtask

  function automatic logic [95:0] rnd_wd();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    // stall, valid, wa0, wa1, wa2, expected req_ready (round-robin from ptr=0)
    tbl[0]  = '{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b001};
    tbl[1]  = '{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b010};
    tbl[2]  = '{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b100};
    tbl[3]  = '{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 3'b001};
    tbl[4]  = '{1'b0, 3'b100, 5'd1, 5'd2, 5'd3, 3'b100};
    tbl[5]  = '{1'b0, 3'b110, 5'd4, 5'd5, 5'd6, 3'b010};
    tbl[6]  = '{1'b0, 3'b100, 5'd4, 5'd5, 5'd6, 3'b100};
    tbl[7]  = '{1'b1, 3'b010, 5'd4, 5'd9, 5'd6, 3'b000};
    tbl[8]  = '{1'b1, 3'b010, 5'd4, 5'd9, 5'd6, 3'b000};
    tbl[9]  = '{1'b0, 3'b010, 5'd4, 5'd9, 5'd6, 3'b010};
    tbl[10] = '{1'b0, 3'b010, 5'd4, 5'd0, 5'd6, 3'b010};
    tbl[11] = '{1'b0, 3'b010, 5'd4, 5'd0, 5'd6, 3'b010};
    tbl[12] = '{1'b0, 3'b010, 5'd4, 5'd0, 5'd6, 3'b010};
    tbl[13] = '{1'b0, 3'b000, 5'd4, 5'd0, 5'd6, 3'b000};
    tbl[14] = '{1'b0, 3'b101, 5'd7, 5'd0, 5'd9, 3'b100};
    tbl[15] = '{1'b0, 3'b001, 5'd7, 5'd0, 5'd9, 3'b001};

    do_reset();

    // single write from requester 0, then two idle cycles
    apply(1'b0, 3'b001, {5'd0, 5'd0, 5'd5}, {64'd0, 32'hDEADBEEF}, 3'b001, 5'd5);
    apply(1'b0, 3'b000, 15'd0, 96'd0, 3'b000, 5'd5);
    apply(1'b0, 3'b000, 15'd0, 96'd0, 3'b000, 5'd5);

    // reset while a write sits in the output stage (ptr is 1 here)
    apply(1'b0, 3'b010, {5'd0, 5'd12, 5'd0}, rnd_wd(), 3'b010, 5'd0);
    chk("midrst_pre_we", 64'(rf_we), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_we", 64'(rf_we), 64'd0);
    chk("midrst_ready", 64'(bus.req_ready), 64'd0);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].st, tbl[i].valid, {tbl[i].wa2, tbl[i].wa1, tbl[i].wa0}, rnd_wd(),
            tbl[i].exp_ready, (i % 2 == 0) ? last_exp.wa : 5'(i));
    end
    apply(1'b0, 3'b000, 15'd0, 96'd0, 3'b000, 5'd0);

    // drive the x0 counter past its limit
    for (int i = 0; i < 260; i++) begin
      apply(1'b0, 3'b010, {5'd3, 5'd0, 5'd1}, rnd_wd(), 3'b010, 5'(i));
    end
    apply(1'b0, 3'b000, 15'd0, 96'd0, 3'b000, 5'd0);
    chk("x0_sat", 64'(x0_drop_cnt), 64'd255);

    // bypass: write x7 three times, probe with matching, zero and other addresses
    apply(1'b0, 3'b001, {5'd0, 5'd0, 5'd7}, {64'd0, 32'h12345678}, 3'b001, 5'd0);
    apply(1'b0, 3'b001, {5'd0, 5'd0, 5'd7}, {64'd0, 32'h12345678}, 3'b001, 5'd7);
    apply(1'b0, 3'b001, {5'd0, 5'd0, 5'd7}, {64'd0, 32'h12345678}, 3'b001, 5'd0);
    apply(1'b0, 3'b000, 15'd0, 96'd0, 3'b000, 5'd8);
    apply(1'b0, 3'b000, 15'd0, 96'd0, 3'b000, 5'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
